calc_controller: RTL and testbench

Top-level sequencer for the calculator datapath. It reads 64-bit operand words from memory, splits each word into two DATA_W operands for the adder, and steers the adder result into the lower and then upper half of the result buffer via the loc_sel control. When both halves are filled, it writes the 64-bit buffer back to memory. It runs a start-to-done job over a contiguous address range, sitting between the host/top level, the memory, the ALU and the result buffer.

---
 rtl/calc_controller_if.sv | 32 +++
 rtl/calc_controller.sv | 131 +++++++++++++
 tb/tb_calc_controller.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_controller_if.sv
// Datapath-side bundle of calc_controller: memory read/write ports, adder operands/carry, result buffer.
// Latency: none (wires only); backpressure: none, memory read data returns a fixed 1 cycle after the strobe.
// Flow control: none; the controller (master) owns all strobes and addresses.
interface calc_controller_if #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
);
    logic                     mem_rd_en_o;
    logic [ADDR_W-1:0]        mem_rd_addr_o;
    logic [MEM_WORD_SIZE-1:0] mem_rd_data_i;
    logic                     mem_wr_en_o;
    logic [ADDR_W-1:0]        mem_wr_addr_o;
    logic [MEM_WORD_SIZE-1:0] mem_wr_data_o;
    logic [DATA_W-1:0]        op_a_o;
    logic [DATA_W-1:0]        op_b_o;
    logic                     carry_i;
    logic                     buf_loc_sel_o;
    logic [MEM_WORD_SIZE-1:0] buf_data_i;

    modport master (
        output mem_rd_en_o, mem_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
               op_a_o, op_b_o, buf_loc_sel_o,
        input  mem_rd_data_i, carry_i, buf_data_i
    );

    modport slave (
        input  mem_rd_en_o, mem_rd_addr_o, mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
               op_a_o, op_b_o, buf_loc_sel_o,
        output mem_rd_data_i, carry_i, buf_data_i
    );
endinterface

// File: rtl/calc_controller.sv
// Sequencer: reads operand words, feeds the adder, fills the result buffer halves, writes results back. Optional sticky carry via CALC_OVERFLOW_EN.
// Latency: 7 cycles per result word (6 when the upper-half read is skipped), plus 1 DONE cycle per job.
// Backpressure: none; memory read data is assumed valid exactly 1 cycle after mem_rd_en_o.
module calc_controller #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 2 * DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    calc_controller_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, READ_LO, LOAD_LO, ADD_LO, READ_HI, LOAD_HI, ADD_HI, WRITE, DONE
    } state_t;

    state_t state_q, state_d;

    // One extra bit so a range ending at the top address is seen as finished rather than wrapping.
    logic [ADDR_W:0]          rd_ptr_q;
    logic [ADDR_W-1:0]        wr_ptr_q;
    logic [ADDR_W-1:0]        end_addr_q;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [DATA_W-1:0]        op_a_q;
    logic [DATA_W-1:0]        op_b_q;
    logic                     skip_hi_q;
    logic                     accept;
    logic                     rd_past_end;
    logic                     is_read;
    logic                     is_write;
    logic                     is_add;

    assign accept      = (state_q == IDLE) && start_i;
    assign rd_past_end = rd_ptr_q > {1'b0, end_addr_q};
    assign is_read     = (state_q == READ_LO) || (state_q == READ_HI);
    assign is_write    = (state_q == WRITE);
    assign is_add      = (state_q == ADD_LO) || (state_q == ADD_HI);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (read_end_addr_i < read_start_addr_i) ? DONE : READ_LO;
            READ_LO: state_d = LOAD_LO;
            LOAD_LO: state_d = ADD_LO;
            ADD_LO:  state_d = rd_past_end ? LOAD_HI : READ_HI;
            READ_HI: state_d = LOAD_HI;
            LOAD_HI: state_d = ADD_HI;
            ADD_HI:  state_d = WRITE;
            WRITE:   state_d = rd_past_end ? DONE : READ_LO;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            end_addr_q <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            skip_hi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_ptr_q   <= {1'b0, read_start_addr_i};
                wr_ptr_q   <= write_start_addr_i;
                end_addr_q <= read_end_addr_i;
            end
            if (is_read) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_addr_q <= rd_ptr_q[ADDR_W-1:0];
            end
            if (state_q == LOAD_LO) begin
                op_a_q <= bus.mem_rd_data_i[DATA_W-1:0];
                op_b_q <= bus.mem_rd_data_i[MEM_WORD_SIZE-1:DATA_W];
            end
            // Odd word count: the missing upper operand word is treated as zero.
            if (state_q == LOAD_HI) begin
                op_a_q <= skip_hi_q ? '0 : bus.mem_rd_data_i[DATA_W-1:0];
                op_b_q <= skip_hi_q ? '0 : bus.mem_rd_data_i[MEM_WORD_SIZE-1:DATA_W];
            end
            if (state_q == ADD_LO) skip_hi_q <= rd_past_end;
            if (is_write) begin
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                wr_addr_q <= wr_ptr_q;
            end
        end
    end

`ifdef CALC_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || accept) overflow_q <= 1'b0;
        else if (is_add && bus.carry_i) overflow_q <= 1'b1;
    end

    assign overflow_o = overflow_q;
`else
    logic unused_carry;

    assign unused_carry = bus.carry_i;
    assign overflow_o   = 1'b0;
`endif

    assign bus.mem_rd_en_o   = is_read;
    assign bus.mem_rd_addr_o = is_read ? rd_ptr_q[ADDR_W-1:0] : rd_addr_q;
    assign bus.mem_wr_en_o   = is_write;
    assign bus.mem_wr_addr_o = is_write ? wr_ptr_q : wr_addr_q;
    assign bus.mem_wr_data_o = bus.buf_data_i;
    assign bus.op_a_o        = op_a_q;
    assign bus.op_b_o        = op_b_q;
    assign bus.buf_loc_sel_o = (state_q == READ_HI) || (state_q == LOAD_HI) ||
                               (state_q == ADD_HI)  || (state_q == WRITE);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == DONE);

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller with behavioural memory, adder and result buffer; writes checked against a scoreboard.
module tb_calc_controller;
    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] rs, re, ws;
    logic       busy_o, done_o, overflow_o;

    calc_controller_if #(.ADDR_W(10), .DATA_W(32), .MEM_WORD_SIZE(64)) bus ();

    calc_controller #(.ADDR_W(10), .DATA_W(32), .MEM_WORD_SIZE(64)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .read_start_addr_i  (rs),
        .read_end_addr_i    (re),
        .write_start_addr_i (ws),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .overflow_o         (overflow_o),
        .bus                (bus)
    );

    logic [63:0] mem [0:1023];
    logic [63:0] buf_q;
    logic [32:0] sum;
    int          cyc = 0;
    int          checks;
    int          passed;
    bit          exp_ovf;

    logic [9:0]  obs_wr_addr_q [$];
    logic [63:0] obs_wr_data_q [$];
    int          obs_wr_cyc_q  [$];
    logic [9:0]  obs_rd_addr_q [$];
    int          obs_rd_cyc_q  [$];
    logic [9:0]  exp_addr_q    [$];
    logic [63:0] exp_data_q    [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adder, buffer and memory read port models.
    assign sum            = {1'b0, bus.op_a_o} + {1'b0, bus.op_b_o};
    assign bus.carry_i    = sum[32];
    assign bus.buf_data_i = buf_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_rd_en_o) bus.mem_rd_data_i <= mem[bus.mem_rd_addr_o];
        if (bus.buf_loc_sel_o) buf_q[63:32] <= sum[31:0];
        else                   buf_q[31:0]  <= sum[31:0];
    end

    always @(negedge clk) begin
        if (bus.mem_wr_en_o) begin
            obs_wr_addr_q.push_back(bus.mem_wr_addr_o);
            obs_wr_data_q.push_back(bus.mem_wr_data_o);
            obs_wr_cyc_q.push_back(cyc);
        end
        if (bus.mem_rd_en_o) begin
            obs_rd_addr_q.push_back(bus.mem_rd_addr_o);
            obs_rd_cyc_q.push_back(cyc);
        end
    end

    task automatic start_job(input logic [9:0] s, input logic [9:0] e, input logic [9:0] w);
        @(negedge clk);
        start = 1'b1; rs = s; re = e; ws = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL reset_busy_done: got %b/%b want 0/0", busy_o, done_o); else passed++;
        checks++; if (bus.mem_rd_en_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0) $display("FAIL reset_strobes: got %b/%b want 0/0", bus.mem_rd_en_o, bus.mem_wr_en_o); else passed++;
        checks++; if (bus.op_a_o !== 32'd0 || bus.op_b_o !== 32'd0) $display("FAIL reset_ops: got %h/%h want 0/0", bus.op_a_o, bus.op_b_o); else passed++;
        checks++; if (overflow_o !== 1'b0 || bus.buf_loc_sel_o !== 1'b0) $display("FAIL reset_ovf_sel: got %b/%b want 0/0", overflow_o, bus.buf_loc_sel_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int wb = obs_wr_addr_q.size();
        int rb = obs_rd_addr_q.size();
        int w0 = wb;
        bit ok;
        mem[0] = {32'd2, 32'd1};
        mem[1] = {32'd20, 32'd10};
        exp_addr_q.push_back(10'h100); exp_data_q.push_back({32'd30, 32'd3});
        start_job(10'd0, 10'd1, 10'h100);
        wait_done(ok);
        checks++; if (!ok) $display("FAIL basic_done: got no done_o within 200 cycles, want pulse"); else passed++;
        while (exp_addr_q.size() > 0) begin
            logic [9:0]  ea = exp_addr_q.pop_front();
            logic [63:0] ed = exp_data_q.pop_front();
            checks++;
            if (wb >= obs_wr_addr_q.size()) $display("FAIL basic_wr: got no write, want %h=%h", ea, ed);
            else if (obs_wr_addr_q[wb] !== ea || obs_wr_data_q[wb] !== ed) $display("FAIL basic_wr: got %h=%h want %h=%h", obs_wr_addr_q[wb], obs_wr_data_q[wb], ea, ed);
            else passed++;
            wb++;
        end
        checks++; if (obs_wr_addr_q.size() !== wb) $display("FAIL basic_wr_count: got %0d want %0d", obs_wr_addr_q.size(), wb); else passed++;
        checks++;
        if (obs_rd_addr_q.size() - rb !== 2 || obs_wr_cyc_q.size() <= w0) $display("FAIL basic_reads: got %0d reads want 2", obs_rd_addr_q.size() - rb);
        else if (obs_rd_addr_q[rb] !== 10'd0 || obs_rd_addr_q[rb+1] !== 10'd1) $display("FAIL basic_reads: got %h,%h want 0,1", obs_rd_addr_q[rb], obs_rd_addr_q[rb+1]);
        else passed++;
        checks++;
        if (obs_wr_cyc_q.size() <= w0 || obs_rd_cyc_q.size() <= rb) $display("FAIL basic_latency: got no transfers want 6");
        else if (obs_wr_cyc_q[w0] - obs_rd_cyc_q[rb] !== 6) $display("FAIL basic_latency: got %0d want 6", obs_wr_cyc_q[w0] - obs_rd_cyc_q[rb]);
        else passed++;
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL basic_after: got done %b busy %b want 0/0", done_o, busy_o); else passed++;
    endtask

    task automatic test_multi_odd;
        int wb = obs_wr_addr_q.size();
        int rb = obs_rd_addr_q.size();
        int w0 = wb;
        bit ok;
        mem[2] = {32'd5, 32'd4};
        exp_addr_q.push_back(10'h100); exp_data_q.push_back({32'd30, 32'd3});
        exp_addr_q.push_back(10'h101); exp_data_q.push_back({32'd0, 32'd9});
        start_job(10'd0, 10'd2, 10'h100);
        wait_done(ok);
        checks++; if (!ok) $display("FAIL multi_done: got no done_o within 200 cycles, want pulse"); else passed++;
        while (exp_addr_q.size() > 0) begin
            logic [9:0]  ea = exp_addr_q.pop_front();
            logic [63:0] ed = exp_data_q.pop_front();
            checks++;
            if (wb >= obs_wr_addr_q.size()) $display("FAIL multi_wr: got no write, want %h=%h", ea, ed);
            else if (obs_wr_addr_q[wb] !== ea || obs_wr_data_q[wb] !== ed) $display("FAIL multi_wr: got %h=%h want %h=%h", obs_wr_addr_q[wb], obs_wr_data_q[wb], ea, ed);
            else passed++;
            wb++;
        end
        checks++; if (obs_wr_addr_q.size() !== wb) $display("FAIL multi_wr_count: got %0d want %0d", obs_wr_addr_q.size(), wb); else passed++;
        checks++;
        if (obs_rd_addr_q.size() - rb !== 3) $display("FAIL multi_reads: got %0d reads want 3 (no read of 3)", obs_rd_addr_q.size() - rb);
        else if (obs_rd_addr_q[rb+2] !== 10'd2) $display("FAIL multi_reads: got last read %h want 2", obs_rd_addr_q[rb+2]);
        else passed++;
        checks++;
        if (obs_wr_cyc_q.size() < w0 + 2 || obs_rd_cyc_q.size() < rb + 3) $display("FAIL multi_latency: got too few transfers want 5");
        else if (obs_wr_cyc_q[w0+1] - obs_rd_cyc_q[rb+2] !== 5) $display("FAIL multi_latency: got %0d want 5", obs_wr_cyc_q[w0+1] - obs_rd_cyc_q[rb+2]);
        else passed++;
    endtask

    task automatic test_empty_and_busy_start;
        int wb = obs_wr_addr_q.size();
        int rb = obs_rd_addr_q.size();
        bit ok;
        start_job(10'd5, 10'd4, 10'h040);
        checks++; if (done_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL empty_done: got done %b busy %b want 1/1", done_o, busy_o); else passed++;
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL empty_idle: got done %b busy %b want 0/0", done_o, busy_o); else passed++;
        checks++; if (obs_rd_addr_q.size() !== rb || obs_wr_addr_q.size() !== wb) $display("FAIL empty_strobes: got %0d reads %0d writes want 0/0", obs_rd_addr_q.size() - rb, obs_wr_addr_q.size() - wb); else passed++;
        exp_addr_q.push_back(10'h100); exp_data_q.push_back({32'd30, 32'd3});
        start_job(10'd0, 10'd1, 10'h100);
        @(negedge clk);
        start = 1'b1; rs = 10'h200; re = 10'h210; ws = 10'h300;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) $display("FAIL busy_start_done: got no done_o within 200 cycles, want pulse"); else passed++;
        while (exp_addr_q.size() > 0) begin
            logic [9:0]  ea = exp_addr_q.pop_front();
            logic [63:0] ed = exp_data_q.pop_front();
            checks++;
            if (wb >= obs_wr_addr_q.size()) $display("FAIL busy_start_wr: got no write, want %h=%h", ea, ed);
            else if (obs_wr_addr_q[wb] !== ea || obs_wr_data_q[wb] !== ed) $display("FAIL busy_start_wr: got %h=%h want %h=%h", obs_wr_addr_q[wb], obs_wr_data_q[wb], ea, ed);
            else passed++;
            wb++;
        end
        checks++;
        if (obs_rd_addr_q.size() - rb !== 2) $display("FAIL busy_start_reads: got %0d reads want 2", obs_rd_addr_q.size() - rb);
        else if (obs_rd_addr_q[rb] !== 10'd0 || obs_rd_addr_q[rb+1] !== 10'd1) $display("FAIL busy_start_reads: got %h,%h want 0,1", obs_rd_addr_q[rb], obs_rd_addr_q[rb+1]);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        int wb = obs_wr_addr_q.size();
        int rb = obs_rd_addr_q.size();
        bit ok;
        mem[1022] = {32'd7, 32'd6};
        mem[1023] = {32'd9, 32'd8};
        exp_addr_q.push_back(10'd1023); exp_data_q.push_back({32'd17, 32'd13});
        start_job(10'd1022, 10'd1023, 10'd1023);
        wait_done(ok);
        checks++; if (!ok) $display("FAIL wrap_done: got no done_o within 200 cycles, want pulse"); else passed++;
        while (exp_addr_q.size() > 0) begin
            logic [9:0]  ea = exp_addr_q.pop_front();
            logic [63:0] ed = exp_data_q.pop_front();
            checks++;
            if (wb >= obs_wr_addr_q.size()) $display("FAIL wrap_wr: got no write, want %h=%h", ea, ed);
            else if (obs_wr_addr_q[wb] !== ea || obs_wr_data_q[wb] !== ed) $display("FAIL wrap_wr: got %h=%h want %h=%h", obs_wr_addr_q[wb], obs_wr_data_q[wb], ea, ed);
            else passed++;
            wb++;
        end
        repeat (10) @(negedge clk);
        checks++; if (obs_rd_addr_q.size() - rb !== 2 || obs_wr_addr_q.size() !== wb) $display("FAIL wrap_terminate: got %0d reads %0d writes want 2/1", obs_rd_addr_q.size() - rb, obs_wr_addr_q.size() - wb + 1); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL wrap_idle: got busy %b want 0", busy_o); else passed++;
    endtask

    task automatic test_overflow;
        int wb = obs_wr_addr_q.size();
        bit ok;
        mem[0] = {32'd1, 32'hFFFF_FFFF};
        exp_addr_q.push_back(10'h010); exp_data_q.push_back(64'd0);
        start_job(10'd0, 10'd0, 10'h010);
        wait_done(ok);
        checks++; if (!ok) $display("FAIL ovf_done: got no done_o within 200 cycles, want pulse"); else passed++;
        checks++; if (overflow_o !== exp_ovf) $display("FAIL ovf_in_done: got %b want %b", overflow_o, exp_ovf); else passed++;
        @(negedge clk);
        checks++; if (overflow_o !== exp_ovf) $display("FAIL ovf_in_idle: got %b want %b", overflow_o, exp_ovf); else passed++;
        while (exp_addr_q.size() > 0) begin
            logic [9:0]  ea = exp_addr_q.pop_front();
            logic [63:0] ed = exp_data_q.pop_front();
            checks++;
            if (wb >= obs_wr_addr_q.size()) $display("FAIL ovf_wr: got no write, want %h=%h", ea, ed);
            else if (obs_wr_addr_q[wb] !== ea || obs_wr_data_q[wb] !== ed) $display("FAIL ovf_wr: got %h=%h want %h=%h", obs_wr_addr_q[wb], obs_wr_data_q[wb], ea, ed);
            else passed++;
            wb++;
        end
        mem[0] = {32'd2, 32'd1};
        start_job(10'd0, 10'd1, 10'h100);
        checks++; if (overflow_o !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow_o); else passed++;
        wait_done(ok);
        checks++; if (!ok || overflow_o !== 1'b0) $display("FAIL ovf_clean_job: got done %b ovf %b want 1/0", ok, overflow_o); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job;
        int wb;
        start_job(10'd0, 10'd1, 10'h180);
        repeat (5) @(negedge clk);
        checks++; if (bus.buf_loc_sel_o !== 1'b1 || bus.mem_rd_en_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0) $display("FAIL midrst_in_add_hi: got sel %b rd %b wr %b want 1/0/0", bus.buf_loc_sel_o, bus.mem_rd_en_o, bus.mem_wr_en_o); else passed++;
        wb = obs_wr_addr_q.size();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || bus.mem_wr_en_o !== 1'b0) $display("FAIL midrst_idle: got busy %b wr %b want 0/0", busy_o, bus.mem_wr_en_o); else passed++;
        checks++; if (bus.op_a_o !== 32'd0 || bus.buf_loc_sel_o !== 1'b0) $display("FAIL midrst_regs: got op_a %h sel %b want 0/0", bus.op_a_o, bus.buf_loc_sel_o); else passed++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (obs_wr_addr_q.size() !== wb || busy_o !== 1'b0) $display("FAIL midrst_no_write: got %0d writes busy %b want 0/0", obs_wr_addr_q.size() - wb, busy_o); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
`ifdef CALC_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst   = 1'b1;
        start = 1'b0;
        rs    = '0;
        re    = '0;
        ws    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
        test_reset;
        test_basic;
        test_multi_odd;
        test_empty_and_busy_start;
        test_wrap;
        test_overflow;
        test_reset_mid_job;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
